// File: rtl/ppc_types.sv
// ppc_types: shared types for the PowerPC execution / write-back datapath.
//   cond_exception_t : CR0 field bits plus the XER bits a result may update.
//   gpr_wb_t         : one write-back record headed for a GPR write port.
// No ports (package).
package ppc_types;

    localparam int GPR_ADDR_W  = 5;
    localparam int GPR_DATA_W  = 32;
    // Reservation-station tags are parametric per block; records carry the
    // widest tag any block uses so one struct fits every configuration.
    localparam int RS_ID_MAX_W = 8;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic so;
        logic xer_so;
        logic xer_ov;
        logic xer_ca;
    } cond_exception_t;

    typedef struct packed {
        logic [RS_ID_MAX_W-1:0] rs_id;
        logic [GPR_ADDR_W-1:0]  reg_addr;
        logic [GPR_DATA_W-1:0]  result;
        cond_exception_t        cr0_xer;
    } gpr_wb_t;

endpackage

// File: rtl/wb_output_slot.sv
// wb_output_slot: single-entry registered write-back slot.
//   clk, rst    : clock, synchronous active-high reset (clears valid and data)
//   load        : capture load_data this cycle (caller only asserts it when
//                 the slot is empty or draining)
//   load_data   : record to capture
//   drain_ready : consumer takes the current record this cycle
//   slot_valid  : slot holds a record
//   slot_data   : record held by the slot
// Load wins over drain, so a draining slot can be refilled back-to-back.
module wb_output_slot
    import ppc_types::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  gpr_wb_t load_data,
    input  logic    drain_ready,
    output logic    slot_valid,
    output gpr_wb_t slot_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= 1'b0;
            slot_data  <= '0;
        end else if (load) begin
            slot_valid <= 1'b1;
            slot_data  <= load_data;
        end else if (drain_ready) begin
            slot_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gpr_write_back_arbiter_mp.sv
// gpr_write_back_arbiter_mp: round-robin arbiter from ARBITER_DEPTH
// reservation-station result outputs onto WRITE_PORTS registered GPR write
// slots, never holding two valid results for the same GPR at once.
//
// Handshake (both sides): a transfer happens on a cycle where valid && ready
// are both high at the clk edge. input_ready is a combinational function of
// input_valid, result_reg_addr_in, output_ready and registered state only; it
// never depends on itself. output_valid and slot payloads come straight from
// flops and do not depend on output_ready.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   input_valid/input_ready    per-requester handshake
//   rs_id_in, result_reg_addr_in, result_in, cr0_xer_in   per-requester payload
//   output_valid/output_ready  per-write-port handshake
//   rs_id_out, result_reg_addr_out, result_out, cr0_xer_out per-port payload
module gpr_write_back_arbiter_mp
    import ppc_types::*;
#(
    parameter int RS_ID_WIDTH   = 5,
    parameter int ARBITER_DEPTH = 8,
    parameter int WRITE_PORTS   = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic            [ARBITER_DEPTH-1:0]        input_valid,
    output logic            [ARBITER_DEPTH-1:0]        input_ready,
    input  logic            [ARBITER_DEPTH-1:0][RS_ID_WIDTH-1:0] rs_id_in,
    input  logic            [ARBITER_DEPTH-1:0][4:0]   result_reg_addr_in,
    input  logic            [ARBITER_DEPTH-1:0][31:0]  result_in,
    input  cond_exception_t [ARBITER_DEPTH-1:0]        cr0_xer_in,
    output logic            [WRITE_PORTS-1:0]          output_valid,
    input  logic            [WRITE_PORTS-1:0]          output_ready,
    output logic            [WRITE_PORTS-1:0][RS_ID_WIDTH-1:0] rs_id_out,
    output logic            [WRITE_PORTS-1:0][4:0]     result_reg_addr_out,
    output logic            [WRITE_PORTS-1:0][31:0]    result_out,
    output cond_exception_t [WRITE_PORTS-1:0]          cr0_xer_out
);

    localparam int PTR_W = $clog2(ARBITER_DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(ARBITER_DEPTH - 1);

    logic [PTR_W-1:0]                  pointer_ff;
    logic [PTR_W-1:0]                  pointer_nxt;
    logic [ARBITER_DEPTH-1:0]          grant;
    logic [WRITE_PORTS-1:0]            slot_load;
    logic [WRITE_PORTS-1:0][PTR_W-1:0] slot_sel;
    logic [WRITE_PORTS-1:0]            slot_open;
    logic [31:0]                       addr_busy;
    logic [PTR_W-1:0]                  scan_idx;
    logic [PTR_W-1:0]                  last_idx;
    logic                              any_grant;
    logic                              slot_taken;
    int                                scan_sum;
    gpr_wb_t [WRITE_PORTS-1:0]         slot_d;
    gpr_wb_t [WRITE_PORTS-1:0]         slot_q;

    // Grant scan. addr_busy starts with the addresses of slots that keep
    // their record this cycle and collects each newly granted address, so a
    // GPR can be claimed by at most one slot at a time.
    always_comb begin
        grant       = '0;
        slot_load   = '0;
        slot_sel    = '0;
        slot_open   = '0;
        addr_busy   = '0;
        scan_idx    = '0;
        last_idx    = '0;
        any_grant   = 1'b0;
        slot_taken  = 1'b0;
        scan_sum    = 0;
        pointer_nxt = pointer_ff;

        for (int p = 0; p < WRITE_PORTS; p++) begin
            slot_open[p] = !output_valid[p] || output_ready[p];
            if (output_valid[p] && !output_ready[p]) begin
                addr_busy[slot_q[p].reg_addr] = 1'b1;
            end
        end

        for (int k = 0; k < ARBITER_DEPTH; k++) begin
            // Explicit wrap: depth need not be a power of two.
            scan_sum = int'(pointer_ff) + k;
            if (scan_sum >= ARBITER_DEPTH) begin
                scan_sum = scan_sum - ARBITER_DEPTH;
            end
            scan_idx = PTR_W'(scan_sum);
            if (slot_open != '0 && input_valid[scan_idx] &&
                !addr_busy[result_reg_addr_in[scan_idx]]) begin
                slot_taken = 1'b0;
                for (int p = 0; p < WRITE_PORTS; p++) begin
                    if (!slot_taken && slot_open[p]) begin
                        slot_open[p] = 1'b0;
                        slot_load[p] = 1'b1;
                        slot_sel[p]  = scan_idx;
                        slot_taken   = 1'b1;
                    end
                end
                grant[scan_idx]                          = 1'b1;
                addr_busy[result_reg_addr_in[scan_idx]]  = 1'b1;
                last_idx                                 = scan_idx;
                any_grant                                = 1'b1;
            end
        end

        if (any_grant) begin
            pointer_nxt = (last_idx == LAST_IDX) ? '0 : last_idx + 1'b1;
        end

        input_ready = rst ? '0 : grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pointer_ff <= '0;
        end else begin
            pointer_ff <= pointer_nxt;
        end
    end

    // Gather the selected requester's payload for each slot; the tag is
    // resized to the record's fixed-width field.
    always_comb begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
            slot_d[p].rs_id    = RS_ID_MAX_W'(rs_id_in[slot_sel[p]]);
            slot_d[p].reg_addr = result_reg_addr_in[slot_sel[p]];
            slot_d[p].result   = result_in[slot_sel[p]];
            slot_d[p].cr0_xer  = cr0_xer_in[slot_sel[p]];
        end
    end

    for (genvar g = 0; g < WRITE_PORTS; g++) begin : g_slot
        wb_output_slot u_slot (
            .clk         (clk),
            .rst         (rst),
            .load        (slot_load[g]),
            .load_data   (slot_d[g]),
            .drain_ready (output_ready[g]),
            .slot_valid  (output_valid[g]),
            .slot_data   (slot_q[g])
        );

        assign rs_id_out[g]           = RS_ID_WIDTH'(slot_q[g].rs_id);
        assign result_reg_addr_out[g] = slot_q[g].reg_addr;
        assign result_out[g]          = slot_q[g].result;
        assign cr0_xer_out[g]         = slot_q[g].cr0_xer;
    end

endmodule

// File: tb/tb_gpr_write_back_arbiter_mp.sv
// Bench for gpr_write_back_arbiter_mp: directed scenarios plus a random phase
// on an 8-requester / 2-port instance, and a wrap scenario on a 5-requester
// instance. A reference model predicts grants and pushes expected records
// into per-slot queues; a monitor pops them as slots drain.
module tb_gpr_write_back_arbiter_mp;
  import ppc_types::*;

  localparam int D  = 8;
  localparam int WP = 2;
  localparam int RW = 5;
  localparam int PW = RW + 5 + 32 + 7;
  localparam int D5 = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (8 x 2) ----------------
  logic            [D-1:0]          input_valid;
  logic            [D-1:0]          input_ready;
  logic            [D-1:0][RW-1:0]  rs_id_in;
  logic            [D-1:0][4:0]     addr_in;
  logic            [D-1:0][31:0]    result_in;
  cond_exception_t [D-1:0]          cr_in;
  logic            [WP-1:0]         output_valid;
  logic            [WP-1:0]         output_ready;
  logic            [WP-1:0][RW-1:0] rs_id_out;
  logic            [WP-1:0][4:0]    addr_out;
  logic            [WP-1:0][31:0]   result_out;
  cond_exception_t [WP-1:0]         cr_out;

  gpr_write_back_arbiter_mp #(.RS_ID_WIDTH(RW), .ARBITER_DEPTH(D), .WRITE_PORTS(WP)) dut (
    .clk(clk), .rst(rst),
    .input_valid(input_valid), .input_ready(input_ready),
    .rs_id_in(rs_id_in), .result_reg_addr_in(addr_in),
    .result_in(result_in), .cr0_xer_in(cr_in),
    .output_valid(output_valid), .output_ready(output_ready),
    .rs_id_out(rs_id_out), .result_reg_addr_out(addr_out),
    .result_out(result_out), .cr0_xer_out(cr_out)
  );

  // ---------------- DUT (5 x 2) ----------------
  logic            [D5-1:0]         valid5;
  logic            [D5-1:0]         ready5;
  logic            [D5-1:0][RW-1:0] rs_id5;
  logic            [D5-1:0][4:0]    addr5;
  logic            [D5-1:0][31:0]   result5;
  cond_exception_t [D5-1:0]         cr5;
  logic            [WP-1:0]         ovalid5;
  logic            [WP-1:0]         oready5;
  logic            [WP-1:0][RW-1:0] rs_id_out5;
  logic            [WP-1:0][4:0]    addr_out5;
  logic            [WP-1:0][31:0]   result_out5;
  cond_exception_t [WP-1:0]         cr_out5;

  gpr_write_back_arbiter_mp #(.RS_ID_WIDTH(RW), .ARBITER_DEPTH(D5), .WRITE_PORTS(WP)) dut5 (
    .clk(clk), .rst(rst),
    .input_valid(valid5), .input_ready(ready5),
    .rs_id_in(rs_id5), .result_reg_addr_in(addr5),
    .result_in(result5), .cr0_xer_in(cr5),
    .output_valid(ovalid5), .output_ready(oready5),
    .rs_id_out(rs_id_out5), .result_reg_addr_out(addr_out5),
    .result_out(result_out5), .cr0_xer_out(cr_out5)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q0[$];
  logic [PW-1:0] exp_q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] req_pay(input int i);
    return {rs_id_in[i], addr_in[i], result_in[i], cr_in[i]};
  endfunction

  function automatic logic [PW-1:0] slot_pay(input int p);
    return {rs_id_out[p], addr_out[p], result_out[p], cr_out[p]};
  endfunction

  // ---------------- reference model ----------------
  // Slots are modelled as (valid, address); grants follow the round-robin
  // rule directly with modulo arithmetic and a queue of free slots.
  logic [WP-1:0] m_valid = '0;
  logic [WP-1:0] n_valid = '0;
  logic [4:0]    m_addr[WP];
  logic [4:0]    n_addr[WP];
  int            m_ptr = 0;
  int            n_ptr = 0;
  logic [D-1:0]  m_ready;
  logic [31:0]   busy;
  int            free_q[$];
  int            mi;
  int            ms;

  always @(negedge clk) begin
    if (rst) begin
      chk("ready_during_rst", 64'(input_ready), 64'd0);
    end else begin
      chk("out_valid", 64'(output_valid), 64'(m_valid));
      chk("pointer", 64'(dut.pointer_ff), 64'(m_ptr));
      busy    = '0;
      free_q  = {};
      m_ready = '0;
      n_valid = m_valid;
      n_addr  = m_addr;
      n_ptr   = m_ptr;
      for (int p = 0; p < WP; p++) begin
        if (m_valid[p] && !output_ready[p]) busy[m_addr[p]] = 1'b1;
        else free_q.push_back(p);
        if (m_valid[p] && output_ready[p]) n_valid[p] = 1'b0;
      end
      for (int k = 0; k < D; k++) begin
        mi = (m_ptr + k) % D;
        if (free_q.size() == 0) break;
        if (input_valid[mi] && !busy[addr_in[mi]]) begin
          ms = free_q.pop_front();
          busy[addr_in[mi]] = 1'b1;
          m_ready[mi] = 1'b1;
          n_valid[ms] = 1'b1;
          n_addr[ms]  = addr_in[mi];
          n_ptr       = (mi + 1) % D;
          if (ms == 0) exp_q0.push_back(req_pay(mi));
          else         exp_q1.push_back(req_pay(mi));
        end
      end
      chk("in_ready", 64'(input_ready), 64'(m_ready));
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid = '0;
      m_ptr   = 0;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      m_valid = n_valid;
      m_addr  = n_addr;
      m_ptr   = n_ptr;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (output_valid[0] && output_ready[0]) begin
        if (exp_q0.size() == 0) chk("slot0_unexpected", 64'(slot_pay(0)), 64'hdead);
        else chk("slot0_data", 64'(slot_pay(0)), 64'(exp_q0.pop_front()));
      end
      if (output_valid[1] && output_ready[1]) begin
        if (exp_q1.size() == 0) chk("slot1_unexpected", 64'(slot_pay(1)), 64'hdead);
        else chk("slot1_data", 64'(slot_pay(1)), 64'(exp_q1.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input logic [4:0] a);
    input_valid[i] = v;
    addr_in[i]     = a;
    rs_id_in[i]    = RW'(i);
    result_in[i]   = $urandom;
    cr_in[i]       = 7'($urandom_range(0, 127));
  endtask

  // Advance one clock; requesters that handed off a result present new data.
  task automatic tick();
    logic [D-1:0] hs;
    hs = input_valid & input_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < D; i++) begin
      if (hs[i]) begin
        result_in[i] = $urandom;
        cr_in[i]     = 7'($urandom_range(0, 127));
      end
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [PW-1:0] p0;
  logic [PW-1:0] p1;
  logic [PW-1:0] p2;

  initial begin
    rst = 1'b1;
    valid5 = '0; rs_id5 = '0; addr5 = '0; result5 = '0; cr5 = '0; oready5 = '0;
    for (int i = 0; i < D; i++) set_req(i, 1'b1, 5'(i + 1));
    output_ready = 2'b11;

    // Reset with all requesters valid.
    repeat (3) begin
      tick();
      chk("rst_in_ready", 64'(input_ready), 64'd0);
      chk("rst_out_valid", 64'(output_valid), 64'd0);
    end
    rst = 1'b0;
    #1;
    chk("rr_grant_01", 64'(input_ready), 64'h03);
    tick();
    chk("post_rst_valid", 64'(output_valid), 64'h3);
    chk("post_rst_ptr", 64'(dut.pointer_ff), 64'd2);
    chk("post_rst_slot0", 64'(rs_id_out[0]), 64'd0);
    chk("post_rst_slot1", 64'(rs_id_out[1]), 64'd1);
    chk("rr_grant_23", 64'(input_ready), 64'h0c);
    tick();
    chk("rr_grant_45", 64'(input_ready), 64'h30);
    tick();
    chk("rr_grant_67", 64'(input_ready), 64'hc0);
    tick();
    chk("rr_grant_01b", 64'(input_ready), 64'h03);
    tick();

    // Address collision: req2 and req5 both target r7.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < D; i++) set_req(i, 1'b0, 5'(i + 1));
    set_req(2, 1'b1, 5'd7);
    set_req(5, 1'b1, 5'd7);
    #1;
    chk("coll_c0_ready", 64'(input_ready), 64'h04);
    tick();
    input_valid[2] = 1'b0;
    #1;
    chk("coll_c1_ready", 64'(input_ready), 64'h20);
    chk("coll_c1_valid", 64'(output_valid), 64'h1);
    chk("coll_c1_slot0", 64'(rs_id_out[0]), 64'd2);
    tick();
    input_valid[5] = 1'b0;
    #1;
    chk("coll_c2_valid", 64'(output_valid), 64'h1);
    chk("coll_c2_slot0", 64'(rs_id_out[0]), 64'd5);
    tick();

    // Backpressure.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    output_ready = 2'b00;
    for (int i = 0; i < D; i++) set_req(i, 1'b1, 5'(i + 1));
    #1;
    chk("bp_fill_ready", 64'(input_ready), 64'h03);
    p0 = req_pay(0);
    p1 = req_pay(1);
    repeat (2) begin
      tick();
      chk("bp_ready", 64'(input_ready), 64'd0);
      chk("bp_valid", 64'(output_valid), 64'h3);
      chk("bp_ptr", 64'(dut.pointer_ff), 64'd2);
      chk("bp_slot0", 64'(slot_pay(0)), 64'(p0));
      chk("bp_slot1", 64'(slot_pay(1)), 64'(p1));
    end
    output_ready = 2'b10;
    #1;
    chk("bp_one_grant", 64'(input_ready), 64'h04);
    p2 = req_pay(2);
    tick();
    output_ready = 2'b00;
    #1;
    chk("bp_slot1_new", 64'(slot_pay(1)), 64'(p2));
    chk("bp_slot0_kept", 64'(slot_pay(0)), 64'(p0));
    chk("bp_ptr_after", 64'(dut.pointer_ff), 64'd3);

    // Mid-stream reset with both slots full.
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(input_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(output_valid), 64'd0);
    chk("mid_rst_ptr", 64'(dut.pointer_ff), 64'd0);
    chk("mid_rst_regrant", 64'(input_ready), 64'h03);
    tick();

    // Random phase: small address space to force collisions.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < D; i++) begin
        input_valid[i] = 1'($urandom_range(0, 1));
        addr_in[i]     = 5'($urandom_range(0, 3));
        rs_id_in[i]    = RW'($urandom);
        result_in[i]   = $urandom;
        cr_in[i]       = 7'($urandom_range(0, 127));
      end
      output_ready = 2'($urandom_range(0, 3));
      #1;
      tick();
    end

    // Drain.
    input_valid  = '0;
    output_ready = 2'b11;
    repeat (3) tick();
    chk("queues_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

    // Non-power-of-two wrap on the 5-requester instance.
    for (int i = 0; i < D5; i++) begin
      valid5[i]  = 1'b1;
      addr5[i]   = 5'(i + 1);
      rs_id5[i]  = RW'(i);
      result5[i] = $urandom;
      cr5[i]     = 7'($urandom_range(0, 127));
    end
    oready5 = 2'b11;
    #1;
    chk("d5_grant_01", 64'(ready5), 64'h03);
    tick();
    chk("d5_grant_23", 64'(ready5), 64'h0c);
    tick();
    chk("d5_ptr4", 64'(dut5.pointer_ff), 64'd4);
    valid5 = 5'b10001;
    #1;
    chk("d5_wrap_ready", 64'(ready5), 64'h11);
    tick();
    chk("d5_wrap_ptr", 64'(dut5.pointer_ff), 64'd1);
    chk("d5_wrap_valid", 64'(ovalid5), 64'h3);
    chk("d5_wrap_slot0", 64'(rs_id_out5[0]), 64'd4);
    chk("d5_wrap_slot1", 64'(rs_id_out5[1]), 64'd0);

    // Final report.
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
